// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with press/release debounce; key_valid rises DEBOUNCE_CNT cycles after detection.
// No backpressure: key_valid is a one-cycle strobe, key_code holds until the next accepted press.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      ci, ci_nxt;
  logic [1:0]      ri, ri_nxt;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic [CW-1:0]   stable, stable_nxt;
  logic [3:0]      row_m, row_s;
  logic            key_valid_nxt;
  logic [3:0]      key_code_nxt;
  logic            key_down_nxt;
  logic            row_hit;

  // Lowest-numbered active row wins when several rows are low.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign col     = ~(4'b0001 << ci);
  assign row_hit = ~row_s[ri];

  always_comb begin
    state_nxt     = state;
    ci_nxt        = ci;
    ri_nxt        = ri;
    dwell_nxt     = dwell;
    stable_nxt    = stable;
    key_valid_nxt = 1'b0;
    key_code_nxt  = key_code;
    key_down_nxt  = key_down;
    case (state)
      ST_SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (row_s == 4'b1111) begin
            ci_nxt = ci + 2'd1;
          end else begin
            ri_nxt     = low_row(row_s);
            stable_nxt = '0;
            state_nxt  = ST_DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!row_hit) begin
          state_nxt = ST_SCAN;
          ci_nxt    = ci + 2'd1;
          dwell_nxt = '0;
        end else if (stable == STABLE_LAST) begin
          key_code_nxt  = {ri, ci};
          key_valid_nxt = 1'b1;
          key_down_nxt  = 1'b1;
          state_nxt     = ST_HOLD;
        end else begin
          stable_nxt = stable + CW'(1);
        end
      end
      ST_HOLD: begin
        if (!row_hit) begin
          state_nxt  = ST_RELEASE;
          stable_nxt = '0;
        end
      end
      ST_RELEASE: begin
        // A re-closed contact is release bounce: go back and wait again.
        if (row_hit) begin
          state_nxt = ST_HOLD;
        end else if (stable == STABLE_LAST) begin
          key_down_nxt = 1'b0;
          state_nxt    = ST_SCAN;
          ci_nxt       = ci + 2'd1;
          dwell_nxt    = '0;
        end else begin
          stable_nxt = stable + CW'(1);
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      ci        <= 2'd0;
      ri        <= 2'd0;
      dwell     <= '0;
      stable    <= '0;
      row_m     <= 4'b1111;
      row_s     <= 4'b1111;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ci        <= ci_nxt;
      ri        <= ri_nxt;
      dwell     <= dwell_nxt;
      stable    <= stable_nxt;
      row_m     <= row;
      row_s     <= row_m;
      key_valid <= key_valid_nxt;
      key_code  <= key_code_nxt;
      key_down  <= key_down_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=8 and a keypad pin model.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_down;

  logic       press_a, press_b;
  logic [3:0] key_a, key_b;
  logic [3:0] vq[$];
  logic [3:0] seq [6];
  int         n_checks;
  int         n_fail;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key k shorts row k/4 to column k%4.
  always_comb begin
    row = 4'b1111;
    if (press_a) row[key_a[3:2]] = col[key_a[1:0]];
    if (press_b) row[key_b[3:2]] = row[key_b[3:2]] & col[key_b[1:0]];
  end

  always @(negedge clk) begin
    if (key_valid) vq.push_back(key_code);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   lat;
    bit   found;
    logic [3:0] e;
    n_checks = 0;
    n_fail   = 0;
    press_a  = 1'b0;
    press_b  = 1'b0;
    key_a    = 4'd0;
    key_b    = 4'd0;
    seq[0] = 4'd1; seq[1] = 4'd10; seq[2] = 4'd5;
    seq[3] = 4'd10; seq[4] = 4'd5; seq[5] = 4'd14;
    rst_n = 1'b0;

    // Reset values and free-running column walk.
    repeat (10) @(posedge clk);
    #1;
    check_val("rst_col", 32'(col), 32'hE);
    check_val("rst_valid", 32'(key_valid), 0);
    check_val("rst_down", 32'(key_down), 0);
    check_val("rst_code", 32'(key_code), 0);
    rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      e = ~(4'b0001 << ((k / 4) % 4));
      check_val("scan_step", 32'(col), 32'(e));
    end
    cycles(1);

    // Press sequence, each key held 500 cycles with 500 idle cycles between.
    vq.delete();
    for (int i = 0; i < 6; i++) begin
      key_a   = seq[i];
      press_a = 1'b1;
      cycles(400);
      check_val("seq_down_hold", 32'(key_down), 1);
      cycles(100);
      press_a = 1'b0;
      cycles(500);
      check_val("seq_down_idle", 32'(key_down), 0);
    end
    check_val("seq_count", 32'(vq.size()), 6);
    for (int i = 0; i < 6; i++)
      check_val("seq_code", (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF_FFFF, 32'(seq[i]));

    // Short bounce on key 6, aligned to the start of column 2's dwell.
    vq.delete();
    for (int i = 0; i < 40 && col == 4'b1011; i++) cycles(1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (col == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    check_val("bounce_align", 32'(found), 1);
    cycles(1);
    key_a   = 4'd6;
    press_a = 1'b1;
    cycles(3);
    check_val("bounce_col_frozen", 32'(col), 32'hB);
    press_a = 1'b0;
    cycles(3);
    check_val("bounce_col_resume", 32'(col), 32'h7);
    cycles(4);
    check_val("bounce_col_wrap", 32'(col), 32'hE);
    check_val("bounce_no_valid", 32'(vq.size()), 0);
    check_val("bounce_down", 32'(key_down), 0);

    // Long hold on key 7, then a release with a 2-cycle re-press glitch.
    vq.delete();
    key_a   = 4'd7;
    press_a = 1'b1;
    cycles(2000);
    check_val("long_count", 32'(vq.size()), 1);
    check_val("long_code", 32'(key_code), 7);
    check_val("long_down", 32'(key_down), 1);
    press_a = 1'b0;
    cycles(4);
    press_a = 1'b1;
    cycles(2);
    press_a = 1'b0;
    check_val("glitch_down", 32'(key_down), 1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycles(1);
      if (!key_down) begin
        lat = k;
        break;
      end
    end
    check_val("glitch_rel_lat", 32'(lat), 32'(2 + DEB + 1));
    cycles(200);
    check_val("glitch_no_repeat", 32'(vq.size()), 1);

    // Two keys in the same column: lowest row wins.
    vq.delete();
    key_a   = 4'd2;
    key_b   = 4'd14;
    press_a = 1'b1;
    press_b = 1'b1;
    cycles(200);
    check_val("multi_count", 32'(vq.size()), 1);
    check_val("multi_code", 32'(key_code), 2);
    press_a = 1'b0;
    press_b = 1'b0;
    cycles(200);
    check_val("multi_down_idle", 32'(key_down), 0);
    check_val("multi_count_end", 32'(vq.size()), 1);

    // Reset while key 9 is held, then re-detection of the same key.
    vq.delete();
    key_a   = 4'd9;
    press_a = 1'b1;
    cycles(100);
    check_val("k9_down", 32'(key_down), 1);
    check_val("k9_code", 32'(key_code), 9);
    rst_n = 1'b0;
    #1;
    check_val("midrst_down", 32'(key_down), 0);
    check_val("midrst_col", 32'(col), 32'hE);
    check_val("midrst_code", 32'(key_code), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vq.delete();
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      cycles(1);
      if (key_valid) begin
        lat = k;
        break;
      end
    end
    check_val("redetect_lat", 32'(lat), 32'(2 * SCAN_DIV + DEB));
    check_val("redetect_code", 32'(key_code), 9);
    check_val("redetect_down", 32'(key_down), 1);
    press_a = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      cycles(1);
      if (!key_down) begin
        lat = k;
        break;
      end
    end
    check_val("release_lat", 32'(lat), 32'(2 + DEB + 1));
    cycles(20);
    check_val("redetect_count", 32'(vq.size()), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
